// File: rtl/spi_pkg.sv
// spi_pkg - shared definitions for the SPI master stage.
//
// Holds the instruction word geometry, the FSM state and transfer-size
// enums, the packed instruction layout and a helper that turns a SIZE
// code into a data-field bit count.
//
// Optional build macro used by the consumers of this package:
//   SPI_SIZE_CHECK_EN - reject SIZE=11 instructions instead of running them
//                       as full-width transfers.

package spi_pkg;

  localparam int DWIDTH       = 32;
  localparam int AWIDTH       = 8;
  localparam int S_ADDR_WIDTH = 2;

  // Packed instruction word: {SS, WR_EN, SIZE[1:0], ADDR, WDATA}
  localparam int INSTR_W = S_ADDR_WIDTH + 3 + AWIDTH + DWIDTH;

  // Longest serial frame: WR_EN + ADDR + full-width data field
  localparam int FRAME_W = 1 + AWIDTH + DWIDTH;
  localparam int NB_W    = $clog2(FRAME_W + 1);
  // Edge counter must reach 2*FRAME_W-1
  localparam int EC_W    = NB_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD
  } spi_state_t;

  typedef enum logic [1:0] {
    SZ8    = 2'b00,
    SZ16   = 2'b01,
    SZFULL = 2'b10,
    SZRSV  = 2'b11
  } spi_size_t;

  typedef struct packed {
    logic [S_ADDR_WIDTH-1:0] ss;
    logic                    wr_en;
    spi_size_t               size;
    logic [AWIDTH-1:0]       addr;
    logic [DWIDTH-1:0]       wdata;
  } spi_instr_t;

  // Width of the data field for a given SIZE code; the reserved code
  // falls back to a full-width transfer.
  function automatic int unsigned data_bits(spi_size_t size);
    case (size)
      SZ8:     return 8;
      SZ16:    return 16;
      default: return DWIDTH;
    endcase
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen - SPI clock divider and edge sequencer.
//
// While 'en' is high the sclk level toggles every CLK_DIV clk cycles.
// The cycle before each toggle raises a one-cycle strobe: lead_stb for
// edges that leave the idle level, trail_stb for edges that return to it.
// edge_cnt counts edges already taken in the current frame. While 'en' is
// low the divider is cleared and sclk follows idle_level.
//
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   en          - run the divider (high only while shifting)
//   idle_level  - sclk level to park at while disabled (CPOL)
//   lead_stb    - next sclk change is a leading edge
//   trail_stb   - next sclk change is a trailing edge
//   edge_cnt    - number of edges already produced in this frame
//   sclk        - SPI clock output

module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            idle_level,
  output logic            lead_stb,
  output logic            trail_stb,
  output logic [EC_W-1:0] edge_cnt,
  output logic            sclk
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] div_cnt;
  logic          tick;

  // Even-numbered edges leave the idle level, odd-numbered ones return to it
  assign tick      = en && (div_cnt == CW'(CLK_DIV - 1));
  assign lead_stb  = tick && !edge_cnt[0];
  assign trail_stb = tick && edge_cnt[0];

  // Half-period divider, edge counter and sclk level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt  <= '0;
      edge_cnt <= '0;
      sclk     <= 1'b0;
    end else if (!en) begin
      div_cnt  <= '0;
      edge_cnt <= '0;
      sclk     <= idle_level;
    end else if (tick) begin
      div_cnt  <= '0;
      edge_cnt <= edge_cnt + 1'b1;
      sclk     <= ~sclk;
    end else begin
      div_cnt  <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master.sv
// spi_master - SPI master stage fed by packed instruction words.
//
// For each instruction the block pulses driver_read, latches the word and
// the {CPOL, CPHA} mode, selects one slave, shifts out the frame
// {WR_EN, ADDR, data field} MSB-first and, for reads, returns the sampled
// data field zero-extended on spi_slv_read_data.
//
// Ports:
//   clk, rst           - clock, asynchronous active-high reset
//   master_en          - allow new instruction fetches
//   driver_data        - instruction word {SS, WR_EN, SIZE, ADDR, WDATA}
//   driver_cfg         - {CPOL, CPHA}, sampled only while loading
//   driver_read        - one-cycle instruction request
//   spi_slv_read_data  - result of the most recent completed read
//   busy               - high whenever the FSM is not idle
//   sclk, mosi, miso   - SPI serial clock and data lines
//   ss_n               - active-low one-hot slave select
//   size_err           - (SPI_SIZE_CHECK_EN only) sticky flag for a
//                        dropped SIZE=11 instruction
//
// Build macro: SPI_SIZE_CHECK_EN enables the SIZE=11 rejection and the
// size_err port. Without it SIZE=11 runs as a full-width transfer.

module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int NSLAVES = 2**S_ADDR_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               master_en,
  input  logic [INSTR_W-1:0] driver_data,
  input  logic [1:0]         driver_cfg,
  output logic               driver_read,
  output logic [DWIDTH-1:0]  spi_slv_read_data,
  output logic               busy,
  output logic               sclk,
  output logic               mosi,
  input  logic               miso,
  output logic [NSLAVES-1:0] ss_n
`ifdef SPI_SIZE_CHECK_EN
  ,
  output logic               size_err
`endif
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  spi_state_t              state_q, state_d;
  spi_instr_t              instr_in;
  logic [S_ADDR_WIDTH-1:0] ss_q;
  logic                    wr_q;
  spi_size_t               size_q;
  logic [1:0]              cfg_q;
  logic [FRAME_W-1:0]      frame_in, tx_sr;
  logic [DWIDTH-1:0]       rx_sr, rx_cur, rd_mask;
  logic [CW-1:0]           ph_cnt;
  logic                    ph_last;
  logic                    load_ok, idle_level;
  logic                    lead_stb, trail_stb, drive_stb, samp_stb, last_edge;
  logic [EC_W-1:0]         edge_cnt, last_edge_idx;

  // Left-aligned serial frame; read frames carry zeros in the data field.
  // The data field is pushed to the top so short transfers end early.
  function automatic logic [FRAME_W-1:0] build_frame(spi_instr_t ins);
    logic [DWIDTH-1:0] data;
    data = '0;
    if (ins.wr_en) data = ins.wdata << (DWIDTH - data_bits(ins.size));
    return {ins.wr_en, ins.addr, data};
  endfunction

  assign instr_in = spi_instr_t'(driver_data);
  assign frame_in = build_frame(instr_in);

`ifdef SPI_SIZE_CHECK_EN
  assign load_ok = (instr_in.size != SZRSV);
`else
  assign load_ok = 1'b1;
`endif

  // While loading, sclk must already park at the incoming CPOL
  assign idle_level = (state_q == ST_LOAD && load_ok) ? driver_cfg[1] : cfg_q[1];

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk        (clk),
    .rst        (rst),
    .en         (state_q == ST_SHIFT),
    .idle_level (idle_level),
    .lead_stb   (lead_stb),
    .trail_stb  (trail_stb),
    .edge_cnt   (edge_cnt),
    .sclk       (sclk)
  );

  // CPHA selects which edge drives mosi and which samples miso
  assign drive_stb     = cfg_q[0] ? lead_stb  : trail_stb;
  assign samp_stb      = cfg_q[0] ? trail_stb : lead_stb;
  assign last_edge_idx = EC_W'(2 * (1 + AWIDTH + data_bits(size_q)) - 1);
  assign last_edge     = trail_stb && (edge_cnt == last_edge_idx);
  assign rx_cur        = samp_stb ? {rx_sr[DWIDTH-2:0], miso} : rx_sr;
  assign rd_mask       = {DWIDTH{1'b1}} >> (DWIDTH - data_bits(size_q));
  assign ph_last       = (ph_cnt == CW'(CLK_DIV - 1));
  assign busy          = (state_q != ST_IDLE);

  // Slave select is only asserted across setup and shifting
  always_comb begin
    ss_n = '1;
    if (state_q == ST_SETUP || state_q == ST_SHIFT) ss_n[ss_q] = 1'b0;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic and the fetch request
  always_comb begin
    state_d     = state_q;
    driver_read = 1'b0;
    case (state_q)
      ST_IDLE:  if (master_en) state_d = ST_FETCH;
      ST_FETCH: begin
        driver_read = 1'b1;
        state_d     = ST_LOAD;
      end
      ST_LOAD:  state_d = load_ok ? ST_SETUP : ST_IDLE;
      ST_SETUP: if (ph_last) state_d = ST_SHIFT;
      ST_SHIFT: if (last_edge) state_d = ST_HOLD;
      ST_HOLD:  if (ph_last) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath: instruction latch, shift registers, mosi and read result.
  // With CPHA=0 the first bit is presented during setup, so one bit is
  // consumed from the frame while loading.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ss_q              <= '0;
      wr_q              <= 1'b0;
      size_q            <= SZ8;
      cfg_q             <= 2'b00;
      tx_sr             <= '0;
      rx_sr             <= '0;
      mosi              <= 1'b0;
      spi_slv_read_data <= '0;
      ph_cnt            <= '0;
    end else begin
      if ((state_q == ST_SETUP || state_q == ST_HOLD) && !ph_last)
        ph_cnt <= ph_cnt + 1'b1;
      else
        ph_cnt <= '0;

      case (state_q)
        ST_LOAD: begin
          if (load_ok) begin
            ss_q   <= instr_in.ss;
            wr_q   <= instr_in.wr_en;
            size_q <= instr_in.size;
            cfg_q  <= driver_cfg;
            if (driver_cfg[0]) begin
              mosi  <= 1'b0;
              tx_sr <= frame_in;
            end else begin
              mosi  <= frame_in[FRAME_W-1];
              tx_sr <= frame_in << 1;
            end
          end
        end
        ST_SETUP: begin
        end
        ST_SHIFT: begin
          if (drive_stb) begin
            mosi  <= tx_sr[FRAME_W-1];
            tx_sr <= tx_sr << 1;
          end
          rx_sr <= rx_cur;
          if (last_edge) begin
            mosi <= 1'b0;
            if (!wr_q) spi_slv_read_data <= rx_cur & rd_mask;
          end
        end
        default: mosi <= 1'b0;
      endcase
    end
  end

`ifdef SPI_SIZE_CHECK_EN
  // Sticky flag for instructions rejected while loading
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                size_err <= 1'b0;
    else if (state_q == ST_LOAD && !load_ok) size_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master - self-checking bench for spi_master.
//
// Acts as the instruction driver and as an SPI slave. Expected frames,
// read results, select windows and request spacing come from a simple
// bit-level model of the transfer rules held in this file.

module tb_spi_master;
  import spi_pkg::*;

  localparam int CLK_DIV = 2;
  localparam int NSL     = 2**S_ADDR_WIDTH;
  localparam logic [NSL-1:0] ALL1 = '1;

  logic               clk = 1'b0;
  logic               rst;
  logic               master_en;
  logic [INSTR_W-1:0] driver_data;
  logic [1:0]         driver_cfg;
  logic               driver_read;
  logic [DWIDTH-1:0]  spi_slv_read_data;
  logic               busy, sclk, mosi, miso;
  logic [NSL-1:0]     ss_n;
`ifdef SPI_SIZE_CHECK_EN
  logic               size_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model state carried between frames
  logic [DWIDTH-1:0] model_rdata = '0;
  int                prev_read_cyc = 0;
  int                exp_gap = 0;
  bit                gap_valid = 0;
  int                fetch_lat_exp = -1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_master #(.CLK_DIV(CLK_DIV), .NSLAVES(NSL)) dut (
    .clk               (clk),
    .rst               (rst),
    .master_en         (master_en),
    .driver_data       (driver_data),
    .driver_cfg        (driver_cfg),
    .driver_read       (driver_read),
    .spi_slv_read_data (spi_slv_read_data),
    .busy              (busy),
    .sclk              (sclk),
    .mosi              (mosi),
    .miso              (miso),
    .ss_n              (ss_n)
`ifdef SPI_SIZE_CHECK_EN
    ,
    .size_err          (size_err)
`endif
  );

  function automatic int dbitsOf(logic [1:0] size);
    if (size == 2'b00) return 8;
    if (size == 2'b01) return 16;
    return DWIDTH;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Serve one instruction as driver and slave, then check the transfer.
  // drop_en_at / rst_at > 0 drop master_en or assert reset at that many
  // cycles after the fetch pulse.
  task automatic applyStimulus(input logic [S_ADDR_WIDTH-1:0] ss, input logic wr,
                               input logic [1:0] size, input logic [AWIDTH-1:0] addr,
                               input logic [DWIDTH-1:0] wdata, input logic [1:0] cfg,
                               input logic [DWIDTH-1:0] resp, input int drop_en_at,
                               input int rst_at);
    int dbits, nbits, step, slv_idx, got_n, ss_low, ss_bad, stray, hold_bad, idle_cnt;
    bit dropped, found, done, seen_ss, prev_ss_act, is_lead;
    logic [63:0] exp_bits, got_bits;
    logic [NSL-1:0] exp_ss;
    logic cpol, cpha, prev_sclk, prev_mosi, sclk_before;
    bit slv[$];

    cpol  = cfg[1];
    cpha  = cfg[0];
    dbits = dbitsOf(size);
    nbits = 1 + AWIDTH + dbits;
    dropped = 1'b0;
`ifdef SPI_SIZE_CHECK_EN
    dropped = (size == 2'b11);
`endif
    exp_ss = ALL1;
    exp_ss[ss] = 1'b0;

    // Expected mosi stream, first bit ends up most significant
    exp_bits = (64'(wr) << AWIDTH) | 64'(addr);
    for (int i = dbits - 1; i >= 0; i--)
      exp_bits = (exp_bits << 1) | (wr ? 64'(wdata[i]) : 64'd0);

    // Slave reply: junk for the command bits, then resp MSB-first
    slv.delete();
    for (int i = 0; i < 1 + AWIDTH; i++) slv.push_back(1'($urandom));
    for (int i = dbits - 1; i >= 0; i--) slv.push_back(resp[i]);

    found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      @(negedge clk);
      if (driver_read) begin
        found = 1'b1;
        if (fetch_lat_exp >= 0) checkOutput("fetch_latency", 64'(k), 64'(fetch_lat_exp));
      end
    end
    fetch_lat_exp = -1;
    checkOutput("fetch_seen", 64'(found), 64'd1);
    if (!found) return;
    if (gap_valid) checkOutput("read_gap", 64'(cyc - prev_read_cyc), 64'(exp_gap));
    checkOutput("rdata_at_fetch", 64'(spi_slv_read_data), 64'(model_rdata));
    prev_read_cyc = cyc;

    driver_data = {ss, wr, size, addr, wdata};
    driver_cfg  = cfg;
    miso        = slv[0];
    sclk_before = sclk;
    slv_idx = 0; got_n = 0; got_bits = '0;
    ss_low = 0; ss_bad = 0; stray = 0; hold_bad = 0;
    seen_ss = 1'b0; prev_ss_act = 1'b0;
    prev_sclk = sclk; prev_mosi = mosi;
    step = 0; done = 1'b0;

    for (int k = 0; k < 5000 && !done; k++) begin
      @(negedge clk);
      step++;
      if (step == 1) checkOutput("read_pulse_width", 64'(driver_read), 64'd0);
      if (step >= 2) begin
        driver_cfg  = 2'($urandom);
        driver_data = INSTR_W'({$urandom, $urandom});
      end
      if (drop_en_at > 0 && step == drop_en_at) master_en = 1'b0;

      if (rst_at > 0 && step == rst_at) begin
        rst = 1'b1;
        #1;
        checkOutput("rst_ss_n", 64'(ss_n), 64'(ALL1));
        checkOutput("rst_sclk", 64'(sclk), 64'd0);
        checkOutput("rst_driver_read", 64'(driver_read), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_mosi", 64'(mosi), 64'd0);
        checkOutput("rst_rdata", 64'(spi_slv_read_data), 64'd0);
`ifdef SPI_SIZE_CHECK_EN
        checkOutput("rst_size_err", 64'(size_err), 64'd0);
`endif
        model_rdata = '0;
        miso = 1'b0;
        master_en = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        gap_valid = 1'b0;
        fetch_lat_exp = 0;
        return;
      end

      if (ss_n != ALL1) begin
        seen_ss = 1'b1;
        ss_low++;
        if (ss_n != exp_ss) ss_bad++;
      end else if (seen_ss && busy) begin
        if (mosi !== 1'b0 || sclk !== cpol) hold_bad++;
      end

      // The slave reacts to sclk edges using line values from before the edge
      if (step >= 3 && sclk !== prev_sclk) begin
        if (!prev_ss_act) stray++;
        else begin
          is_lead = (sclk != cpol);
          if (is_lead != cpha) begin
            got_bits = (got_bits << 1) | 64'(prev_mosi);
            got_n++;
          end else if (cpha) begin
            miso = (slv_idx < nbits) ? slv[slv_idx] : 1'b0;
            slv_idx++;
          end else begin
            slv_idx++;
            miso = (slv_idx < nbits) ? slv[slv_idx] : 1'b0;
          end
        end
      end
      prev_sclk   = sclk;
      prev_mosi   = mosi;
      prev_ss_act = (ss_n != ALL1);
      if (!busy) done = 1'b1;
    end

    checkOutput("frame_done", 64'(done), 64'd1);
    if (dropped) begin
      checkOutput("drop_ss_window", 64'(ss_low), 64'd0);
      checkOutput("drop_sclk_quiet", 64'(sclk), 64'(sclk_before));
`ifdef SPI_SIZE_CHECK_EN
      checkOutput("size_err", 64'(size_err), 64'd1);
`endif
      exp_gap = 3;
    end else begin
      checkOutput("ss_window", 64'(ss_low), 64'(CLK_DIV * (1 + 2 * nbits)));
      checkOutput("ss_onehot", 64'(ss_bad), 64'd0);
      checkOutput("bit_count", 64'(got_n), 64'(nbits));
      checkOutput("mosi_frame", got_bits, exp_bits);
      checkOutput("stray_edges", 64'(stray), 64'd0);
      checkOutput("hold_lines", 64'(hold_bad), 64'd0);
      checkOutput("sclk_idle", 64'(sclk), 64'(cpol));
      if (!wr) model_rdata = DWIDTH'(64'(resp) % (64'd1 << dbits));
      exp_gap = 3 + CLK_DIV * (2 + 2 * nbits);
    end
    checkOutput("rdata_after", 64'(spi_slv_read_data), 64'(model_rdata));

    if (!master_en) begin
      idle_cnt = 0;
      repeat (20) begin
        @(negedge clk);
        if (driver_read) idle_cnt++;
      end
      checkOutput("no_fetch_disabled", 64'(idle_cnt), 64'd0);
      master_en = 1'b1;
      gap_valid = 1'b0;
      fetch_lat_exp = 0;
    end else begin
      gap_valid = 1'b1;
    end
  endtask

  initial begin
    int idle_reads;
    rst = 1'b1;
    master_en = 1'b0;
    driver_data = '0;
    driver_cfg = 2'b00;
    miso = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_driver_read", 64'(driver_read), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_sclk", 64'(sclk), 64'd0);
    checkOutput("reset_mosi", 64'(mosi), 64'd0);
    checkOutput("reset_ss_n", 64'(ss_n), 64'(ALL1));
    checkOutput("reset_rdata", 64'(spi_slv_read_data), 64'd0);
    rst = 1'b0;
    idle_reads = 0;
    repeat (5) begin
      @(negedge clk);
      if (driver_read || busy) idle_reads++;
    end
    checkOutput("idle_no_fetch", 64'(idle_reads), 64'd0);
    master_en = 1'b1;
    fetch_lat_exp = 0;

    $display("[TB] directed frames");
    applyStimulus(2'd1, 1'b1, 2'b00, 8'hA5, 32'h0000003C, 2'b00, $urandom, 0, 0);
    applyStimulus(2'd2, 1'b0, 2'b01, 8'h12, 32'h0, 2'b11, 32'hDEADBEEF, 0, 0);
    applyStimulus(2'd0, 1'b1, 2'b10, 8'h5A, 32'h11223344, 2'b01, $urandom, 0, 0);
    applyStimulus(2'd3, 1'b0, 2'b00, 8'hC3, 32'h0, 2'b10, 32'h1234567E, 0, 0);
    applyStimulus(2'd1, 1'b0, 2'b11, 8'h3C, 32'h0, 2'b00, $urandom, 0, 0);
    applyStimulus(2'd2, 1'b0, 2'b01, 8'h81, 32'h0, 2'b01, 32'h0000A55A, 10, 0);
    applyStimulus(2'd3, 1'b1, 2'b10, 8'h77, 32'hCAFEF00D, 2'b00, $urandom, 0, 15);

    $display("[TB] random frames");
    for (int i = 0; i < 10; i++)
      applyStimulus(S_ADDR_WIDTH'($urandom), 1'($urandom), 2'($urandom), AWIDTH'($urandom),
                    $urandom, 2'($urandom), $urandom, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
